pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.
- Detects load-use hazards in ID/EX.
- Freezes the pipe while data memory is busy, with a watchdog timeout.
- Flushes on a taken branch resolved in MEM; drains the pipe and redirects on an arithmetic overflow exception.

Parameters:
- EXC_DRAIN, 2: cycles spent in EXC state flushing the pipe after an exception (min 1).
- MEM_TIMEOUT, 15: max cycles waiting for MemReady before raising MemErr (min 1).

Ports:
- clk  in  1  pipeline clock; pipeline registers capture on negedge, controller state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- IdRs  in  5  rs field of the instruction in ID.
- IdRt  in  5  rt field of the instruction in ID.
- ExRw  in  5  destination register of the instruction in EX.
- ExMemtoReg  in  1  instruction in EX is a load.
- MemBranch  in  1  instruction in MEM is a branch.
- MemZero  in  1  ALU zero flag of the instruction in MEM.
- MemOverflow  in  1  ALU overflow of the instruction in MEM.
- MemReq  in  1  instruction in MEM accesses data memory (load or store).
- MemReady  in  1  data memory completes the access this cycle.
- PcWrite  out  1  PC update enable.
- IfIdWrite  out  1  IF/ID register load enable.
- IdExWrite  out  1  ID/EX register load enable.
- ExMemWrite  out  1  EX/MEM register load enable.
- IfIdFlush  out  1  IF/ID register loads a bubble.
- IdExFlush  out  1  ID/EX register loads a bubble (all control bits 0).
- ExMemFlush  out  1  EX/MEM register loads a bubble.
- PcSel  out  2  next-PC select: 0 sequential, 1 branch target, 2 exception vector.
- ExcPending  out  1  high while in EXC state.
- MemErr  out  1  sticky; set on memory timeout, cleared only by rst.
- StallCount  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- States: RUN, MEMWAIT, EXC. Outputs are combinational from state and inputs; state and counters update on posedge clk.
- While rst is high:
  - state = RUN; counters = 0; MemErr = 0; StallCount = 0.
  - All *Write = 0; all *Flush = 1; PcSel = 0; ExcPending = 0.
- Reset asserted mid-stall or mid-exception aborts the sequence; there is no resume.
- RUN defaults: all *Write = 1, all *Flush = 0, PcSel = 0.
- RUN conditions are evaluated in priority order; only the highest active condition takes effect:
  1. Overflow: MemOverflow = 1.
     - Cycle outputs: IfIdFlush = IdExFlush = ExMemFlush = 1, PcSel = 2.
     - Next state EXC, drain counter = EXC_DRAIN - 1.
  2. Memory busy: MemReq = 1 and MemReady = 0.
     - Cycle outputs: all *Write = 0.
     - Next state MEMWAIT, wait counter = 1.
  3. Branch taken: MemBranch & MemZero.
     - Cycle outputs: PcSel = 1, IfIdFlush = IdExFlush = ExMemFlush = 1.
     - Stay in RUN. The instruction in MEM completes normally.
  4. Load-use: ExMemtoReg = 1, ExRw != 0, and (ExRw == IdRs or ExRw == IdRt).
     - Cycle outputs: PcWrite = IfIdWrite = 0, IdExFlush = 1. Exactly one bubble.
     - Stay in RUN.
- MEMWAIT:
  - Outputs: all *Write = 0, no flush.
  - MemReady = 1: outputs revert to RUN defaults that cycle; next state RUN. A branch/overflow in MEM is re-evaluated in RUN on the following cycle.
  - Otherwise the wait counter increments.
  - Timeout: wait counter reaches MEM_TIMEOUT with no MemReady → set MemErr, next state EXC (drain as for overflow). Exception-redirect outputs (PcSel = 2, all flushes) are asserted on the cycle of EXC entry.
- EXC:
  - Outputs: ExcPending = 1; PcWrite = 0; IfIdFlush = IdExFlush = ExMemFlush = 1; *Write = 1 (bubbles load); PcSel = 0.
  - Drain counter decrements each cycle; at 0, next state RUN. Total EXC residency = EXC_DRAIN cycles.
  - All inputs are ignored in EXC.
- Counter widths: wide enough for MEM_TIMEOUT and EXC_DRAIN; no wraparound is reachable.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- When defined: StallCount increments by 1 every cycle in which PcWrite = 0 and rst = 0. It saturates at 0xFFFFFFFF.
- When undefined: StallCount is tied to 0 and no counter register exists.

Test Plan:
- Load-use: ExMemtoReg = 1, ExRw = 5, IdRt = 5 for one cycle → PcWrite = 0, IfIdWrite = 0, IdExFlush = 1 for exactly 1 cycle. Repeat with ExRw = 0 → no stall.
- Memory wait: MemReq = 1, MemReady low for 3 cycles then high → all *Write = 0 for 3 cycles, RUN on the 4th; StallCount = 3 with PIPE_STALL_CNT_EN.
- Timeout (MEM_TIMEOUT = 15): MemReq = 1, MemReady held 0 → MemErr = 1 after 15 wait cycles, then ExcPending = 1 for 2 cycles, then RUN; MemErr stays 1.
- Priority: MemOverflow = 1, MemBranch = MemZero = 1, and a load-use hazard together → PcSel = 2, all flushes, EXC for 2 cycles; no PcSel = 1 seen.
- Branch taken: MemBranch = 1, MemZero = 1 → PcSel = 1 and three flushes for 1 cycle. With MemZero = 0 → PcSel = 0, no flush.
- Async reset: assert rst mid-EXC between clock edges → ExcPending drops immediately, all *Flush = 1 while rst is high, state RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and pipe_hazard_ctrl.
// master = pipeline datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if;
    logic [4:0]  IdRs;
    logic [4:0]  IdRt;
    logic [4:0]  ExRw;
    logic        ExMemtoReg;
    logic        MemBranch;
    logic        MemZero;
    logic        MemOverflow;
    logic        MemReq;
    logic        MemReady;
    logic        PcWrite;
    logic        IfIdWrite;
    logic        IdExWrite;
    logic        ExMemWrite;
    logic        IfIdFlush;
    logic        IdExFlush;
    logic        ExMemFlush;
    logic [1:0]  PcSel;
    logic        ExcPending;
    logic        MemErr;
    logic [31:0] StallCount;

    modport master (
        output IdRs, IdRt, ExRw, ExMemtoReg, MemBranch, MemZero, MemOverflow,
               MemReq, MemReady,
        input  PcWrite, IfIdWrite, IdExWrite, ExMemWrite, IfIdFlush, IdExFlush,
               ExMemFlush, PcSel, ExcPending, MemErr, StallCount
    );

    modport slave (
        input  IdRs, IdRt, ExRw, ExMemtoReg, MemBranch, MemZero, MemOverflow,
               MemReq, MemReady,
        output PcWrite, IfIdWrite, IdExWrite, ExMemWrite, IfIdFlush, IdExFlush,
               ExMemFlush, PcSel, ExcPending, MemErr, StallCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, memory wait with watchdog, branch, overflow.
// Optional macro PIPE_STALL_CNT_EN adds a saturating stall-cycle counter on StallCount.
module pipe_hazard_ctrl #(
    parameter int unsigned EXC_DRAIN   = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int unsigned WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DRAIN_W = (EXC_DRAIN < 2) ? 1 : $clog2(EXC_DRAIN + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(EXC_DRAIN - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_EXC     = 2'd2
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [WAIT_W-1:0]    wait_cnt_nxt_s;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic [DRAIN_W-1:0]   drain_cnt_nxt_s;
    logic                 mem_err_r;
    logic                 mem_err_set_s;

    logic                 pc_write_s;
    logic                 ifid_write_s;
    logic                 idex_write_s;
    logic                 exmem_write_s;
    logic                 ifid_flush_s;
    logic                 idex_flush_s;
    logic                 exmem_flush_s;
    logic [1:0]           pc_sel_s;
    logic                 exc_pending_s;

    logic                 load_use_s;
    logic                 mem_busy_s;
    logic                 br_taken_s;

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(input logic       is_load,
                                          input logic [4:0] rw,
                                          input logic [4:0] rs,
                                          input logic [4:0] rt);
        return is_load && (rw != 5'd0) && ((rw == rs) || (rw == rt));
    endfunction

    assign load_use_s = load_use_hit(hz.ExMemtoReg, hz.ExRw, hz.IdRs, hz.IdRt);
    assign mem_busy_s = hz.MemReq && !hz.MemReady;
    assign br_taken_s = hz.MemBranch && hz.MemZero;

    // Next-state, counter update and pipeline control decode.
    always_comb begin
        next_state_s    = state_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        drain_cnt_nxt_s = drain_cnt_r;
        mem_err_set_s   = 1'b0;
        pc_write_s      = 1'b1;
        ifid_write_s    = 1'b1;
        idex_write_s    = 1'b1;
        exmem_write_s   = 1'b1;
        ifid_flush_s    = 1'b0;
        idex_flush_s    = 1'b0;
        exmem_flush_s   = 1'b0;
        pc_sel_s        = 2'd0;
        exc_pending_s   = 1'b0;

        if (rst) begin
            next_state_s  = ST_RUN;
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b0;
            exmem_write_s = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hz.MemOverflow) begin
                        ifid_flush_s    = 1'b1;
                        idex_flush_s    = 1'b1;
                        exmem_flush_s   = 1'b1;
                        pc_sel_s        = 2'd2;
                        next_state_s    = ST_EXC;
                        drain_cnt_nxt_s = DRAIN_INIT;
                    end else if (mem_busy_s) begin
                        pc_write_s      = 1'b0;
                        ifid_write_s    = 1'b0;
                        idex_write_s    = 1'b0;
                        exmem_write_s   = 1'b0;
                        next_state_s    = ST_MEMWAIT;
                        wait_cnt_nxt_s  = WAIT_W'(1);
                    end else if (br_taken_s) begin
                        pc_sel_s        = 2'd1;
                        ifid_flush_s    = 1'b1;
                        idex_flush_s    = 1'b1;
                        exmem_flush_s   = 1'b1;
                    end else if (load_use_s) begin
                        pc_write_s      = 1'b0;
                        ifid_write_s    = 1'b0;
                        idex_flush_s    = 1'b1;
                    end else begin
                        next_state_s    = ST_RUN;
                    end
                end

                ST_MEMWAIT: begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_write_s  = 1'b0;
                    exmem_write_s = 1'b0;
                    if (hz.MemReady) begin
                        pc_write_s     = 1'b1;
                        ifid_write_s   = 1'b1;
                        idex_write_s   = 1'b1;
                        exmem_write_s  = 1'b1;
                        next_state_s   = ST_RUN;
                        wait_cnt_nxt_s = '0;
                    end else if (wait_cnt_r >= WAIT_LAST) begin
                        // Watchdog expiry: redirect to the exception vector on this cycle.
                        pc_write_s      = 1'b1;
                        ifid_write_s    = 1'b1;
                        idex_write_s    = 1'b1;
                        exmem_write_s   = 1'b1;
                        ifid_flush_s    = 1'b1;
                        idex_flush_s    = 1'b1;
                        exmem_flush_s   = 1'b1;
                        pc_sel_s        = 2'd2;
                        mem_err_set_s   = 1'b1;
                        next_state_s    = ST_EXC;
                        wait_cnt_nxt_s  = '0;
                        drain_cnt_nxt_s = DRAIN_INIT;
                    end else begin
                        wait_cnt_nxt_s  = wait_cnt_r + WAIT_W'(1);
                    end
                end

                ST_EXC: begin
                    exc_pending_s = 1'b1;
                    pc_write_s    = 1'b0;
                    ifid_flush_s  = 1'b1;
                    idex_flush_s  = 1'b1;
                    exmem_flush_s = 1'b1;
                    if (drain_cnt_r == '0) begin
                        next_state_s    = ST_RUN;
                    end else begin
                        drain_cnt_nxt_s = drain_cnt_r - DRAIN_W'(1);
                    end
                end

                default: begin
                    // Illegal encoding: park in RUN with the pipe frozen and flushed.
                    next_state_s    = ST_RUN;
                    wait_cnt_nxt_s  = '0;
                    drain_cnt_nxt_s = '0;
                    pc_write_s      = 1'b0;
                    ifid_write_s    = 1'b0;
                    idex_write_s    = 1'b0;
                    exmem_write_s   = 1'b0;
                    ifid_flush_s    = 1'b1;
                    idex_flush_s    = 1'b1;
                    exmem_flush_s   = 1'b1;
                end
            endcase
        end
    end

    // Controller state, wait/drain counters and sticky memory error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= '0;
            drain_cnt_r <= '0;
            mem_err_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            mem_err_r   <= mem_err_r | mem_err_set_s;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles with the PC frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (!pc_write_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hz.StallCount = stall_cnt_r;
`else
    assign hz.StallCount = 32'd0;
`endif

    assign hz.PcWrite    = pc_write_s;
    assign hz.IfIdWrite  = ifid_write_s;
    assign hz.IdExWrite  = idex_write_s;
    assign hz.ExMemWrite = exmem_write_s;
    assign hz.IfIdFlush  = ifid_flush_s;
    assign hz.IdExFlush  = idex_flush_s;
    assign hz.ExMemFlush = exmem_flush_s;
    assign hz.PcSel      = pc_sel_s;
    assign hz.ExcPending = exc_pending_s;
    assign hz.MemErr     = mem_err_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (EXC_DRAIN=2, MEM_TIMEOUT=15).
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_hazard_ctrl_if pif ();

    pipe_hazard_ctrl #(.EXC_DRAIN(2), .MEM_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PcWrite,IfIdWrite,IdExWrite,ExMemWrite, IfIdFlush,IdExFlush,ExMemFlush, PcSel, ExcPending}
    localparam logic [9:0] C_RST   = 10'b0000_111_00_0;
    localparam logic [9:0] C_RUN   = 10'b1111_000_00_0;
    localparam logic [9:0] C_STALL = 10'b0000_000_00_0;
    localparam logic [9:0] C_LU    = 10'b0011_010_00_0;
    localparam logic [9:0] C_BR    = 10'b1111_111_01_0;
    localparam logic [9:0] C_OVF   = 10'b1111_111_10_0;
    localparam logic [9:0] C_EXC   = 10'b0111_111_00_1;

`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    function automatic logic [9:0] ctl();
        return {pif.PcWrite, pif.IfIdWrite, pif.IdExWrite, pif.ExMemWrite,
                pif.IfIdFlush, pif.IdExFlush, pif.ExMemFlush, pif.PcSel, pif.ExcPending};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        pif.IdRs        = 5'd0;
        pif.IdRt        = 5'd0;
        pif.ExRw        = 5'd0;
        pif.ExMemtoReg  = 1'b0;
        pif.MemBranch   = 1'b0;
        pif.MemZero     = 1'b0;
        pif.MemOverflow = 1'b0;
        pif.MemReq      = 1'b0;
        pif.MemReady    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        clr_in();
        #2;
        chk("reset_ctl", 32'(ctl()), 32'(C_RST));
        chk("reset_err", 32'(pif.MemErr), 32'd0);
        chk("reset_cnt", pif.StallCount, 32'd0);
        tick();
        rst = 1'b0;

        // Idle RUN
        @(negedge clk); chk("idle", 32'(ctl()), 32'(C_RUN));
        tick();

        // Load-use through rt, exactly one bubble
        pif.ExMemtoReg = 1'b1; pif.ExRw = 5'd5; pif.IdRt = 5'd5; pif.IdRs = 5'd1;
        @(negedge clk); chk("lu_rt", 32'(ctl()), 32'(C_LU));
        tick();
        clr_in();
        @(negedge clk); chk("lu_after", 32'(ctl()), 32'(C_RUN));
        tick();
        // Load-use through rs
        pif.ExMemtoReg = 1'b1; pif.ExRw = 5'd7; pif.IdRs = 5'd7; pif.IdRt = 5'd3;
        @(negedge clk); chk("lu_rs", 32'(ctl()), 32'(C_LU));
        tick();
        // Load to r0 is no hazard
        pif.ExMemtoReg = 1'b1; pif.ExRw = 5'd0; pif.IdRs = 5'd0; pif.IdRt = 5'd0;
        @(negedge clk); chk("lu_r0", 32'(ctl()), 32'(C_RUN));
        tick();
        // Matching register but not a load
        pif.ExMemtoReg = 1'b0; pif.ExRw = 5'd9; pif.IdRs = 5'd9;
        @(negedge clk); chk("lu_noload", 32'(ctl()), 32'(C_RUN));
        tick();
        clr_in();

        // Memory wait: 3 busy cycles then ready
        do_reset();
        pif.MemReq = 1'b1; pif.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk($sformatf("memwait_%0d", i), 32'(ctl()), 32'(C_STALL));
            tick();
        end
        pif.MemReady = 1'b1;
        @(negedge clk); chk("memwait_ready", 32'(ctl()), 32'(C_RUN));
        tick();
        clr_in();
        @(negedge clk);
        chk("memwait_run", 32'(ctl()), 32'(C_RUN));
        chk("memwait_cnt", pif.StallCount, CNT_EN ? 32'd3 : 32'd0);
        chk("memwait_err", 32'(pif.MemErr), 32'd0);
        tick();

        // Branch taken / not taken
        pif.MemBranch = 1'b1; pif.MemZero = 1'b1;
        @(negedge clk); chk("br_taken", 32'(ctl()), 32'(C_BR));
        tick();
        pif.MemZero = 1'b0;
        @(negedge clk); chk("br_not_taken", 32'(ctl()), 32'(C_RUN));
        tick();
        clr_in();

        // Priority: overflow beats branch and load-use; inputs ignored in EXC
        pif.MemOverflow = 1'b1; pif.MemBranch = 1'b1; pif.MemZero = 1'b1;
        pif.ExMemtoReg = 1'b1; pif.ExRw = 5'd4; pif.IdRs = 5'd4;
        @(negedge clk); chk("prio_ovf", 32'(ctl()), 32'(C_OVF));
        tick();
        @(negedge clk); chk("prio_exc0", 32'(ctl()), 32'(C_EXC));
        tick();
        @(negedge clk); chk("prio_exc1", 32'(ctl()), 32'(C_EXC));
        tick();
        clr_in();
        @(negedge clk); chk("prio_run", 32'(ctl()), 32'(C_RUN));
        tick();

        // Watchdog timeout
        do_reset();
        pif.MemReq = 1'b1; pif.MemReady = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); chk($sformatf("tmo_wait_%0d", i), 32'(ctl()), 32'(C_STALL));
            tick();
        end
        @(negedge clk);
        chk("tmo_redirect", 32'(ctl()), 32'(C_OVF));
        chk("tmo_err_pre", 32'(pif.MemErr), 32'd0);
        tick();
        clr_in();
        @(negedge clk);
        chk("tmo_exc0", 32'(ctl()), 32'(C_EXC));
        chk("tmo_err", 32'(pif.MemErr), 32'd1);
        tick();
        @(negedge clk); chk("tmo_exc1", 32'(ctl()), 32'(C_EXC));
        tick();
        @(negedge clk);
        chk("tmo_run", 32'(ctl()), 32'(C_RUN));
        chk("tmo_err_sticky", 32'(pif.MemErr), 32'd1);
        chk("tmo_cnt", pif.StallCount, CNT_EN ? 32'd16 : 32'd0);
        tick();

        // Async reset in the middle of EXC
        pif.MemOverflow = 1'b1;
        @(negedge clk); chk("ar_ovf", 32'(ctl()), 32'(C_OVF));
        tick();
        clr_in();
        @(negedge clk); chk("ar_exc", 32'(ctl()), 32'(C_EXC));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rst_ctl", 32'(ctl()), 32'(C_RST));
        chk("ar_rst_err", 32'(pif.MemErr), 32'd0);
        tick();
        chk("ar_rst_hold", 32'(ctl()), 32'(C_RST));
        rst = 1'b0;
        @(negedge clk); chk("ar_run0", 32'(ctl()), 32'(C_RUN));
        tick();
        @(negedge clk); chk("ar_run1", 32'(ctl()), 32'(C_RUN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
